// File: rtl/mem_access_unit_pkg.sv
// Shared load/store mode encodings, FSM states and bus constants for the memory access unit.
package mem_access_unit_pkg;

  localparam int L_S_MODE_W = 3;

  localparam logic [L_S_MODE_W-1:0] L_S_BYTE   = 3'd0;
  localparam logic [L_S_MODE_W-1:0] L_S_BYTE_U = 3'd1;
  localparam logic [L_S_MODE_W-1:0] L_S_HALF   = 3'd2;
  localparam logic [L_S_MODE_W-1:0] L_S_HALF_U = 3'd3;
  localparam logic [L_S_MODE_W-1:0] L_S_WORD   = 3'd4;

  localparam int DBUS_BE_W           = 4;
  localparam int MAU_TIMEOUT_DEFAULT = 256;

  typedef enum logic [1:0] {
    MAU_IDLE = 2'd0,
    MAU_WAIT = 2'd1,
    MAU_DONE = 2'd2
  } mau_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational little-endian lane steering: byte enables, replicated store data,
// extended load data and misalignment flag from (mode, addr[1:0]). No latency, no flow control.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [L_S_MODE_W-1:0] mode,
  input  logic [1:0]            addr_lo,
  input  logic [31:0]           store_data,
  input  logic [31:0]           rdata,
  output logic [DBUS_BE_W-1:0]  be,
  output logic [31:0]           wdata,
  output logic [31:0]           load_data,
  output logic                  misaligned
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
  assign lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be         = '0;
    wdata      = store_data;
    load_data  = rdata;
    misaligned = 1'b1;  // undefined modes are treated as illegal accesses
    case (mode)
      L_S_BYTE, L_S_BYTE_U: begin
        be         = 4'b0001 << addr_lo;
        wdata      = {4{store_data[7:0]}};
        load_data  = (mode == L_S_BYTE) ? {{24{lane_b[7]}}, lane_b} : {24'b0, lane_b};
        misaligned = 1'b0;
      end
      L_S_HALF, L_S_HALF_U: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        load_data  = (mode == L_S_HALF) ? {{16{lane_h[15]}}, lane_h} : {16'b0, lane_h};
        misaligned = addr_lo[0];
      end
      L_S_WORD: begin
        be         = 4'b1111;
        misaligned = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: one req/ack data-bus transaction per load/store, result in the cycle after ack.
// Stalls upstream from op acceptance until DONE; bus_err after TIMEOUT_CYCLES wait cycles.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = MAU_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_en,
  input  logic                  mem_write_en,
  input  logic [L_S_MODE_W-1:0] l_s_mode,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     store_data,
  output logic                  mem_stall,
  output logic [DATA_W-1:0]     load_data,
  output logic                  load_valid,
  output logic                  addr_err,
  output logic                  bus_err,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [ADDR_W-1:0]     dbus_addr,
  output logic [DBUS_BE_W-1:0]  dbus_be,
  output logic [DATA_W-1:0]     dbus_wdata,
  input  logic                  dbus_ack,
  input  logic [DATA_W-1:0]     dbus_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  mau_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic [L_S_MODE_W-1:0] mode_q, mode_d;
  logic [DBUS_BE_W-1:0]  be_q, be_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d, load_data_q, load_data_d;
  logic                  load_valid_q, load_valid_d, addr_err_q, addr_err_d, bus_err_q, bus_err_d;

  logic                  in_wait, op, legal_op;
  logic [DBUS_BE_W-1:0]  al_be;
  logic [DATA_W-1:0]     al_wdata, al_load;
  logic                  al_misaligned;

  assign in_wait = (state_q == MAU_WAIT);

  // The aligner formats the incoming op while idle and the latched op while waiting for rdata.
  mem_lane_align u_align (
    .mode       (in_wait ? mode_q : l_s_mode),
    .addr_lo    (in_wait ? addr_lo_q : mem_addr[1:0]),
    .store_data (store_data),
    .rdata      (dbus_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_misaligned)
  );

  assign op        = mem_read_en | mem_write_en;
  assign legal_op  = op & ~(mem_read_en & mem_write_en) & ~al_misaligned;
  assign mem_stall = ~rst & (in_wait | ((state_q == MAU_IDLE) & legal_op));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    addr_lo_d    = addr_lo_q;
    mode_d       = mode_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    addr_err_d   = 1'b0;
    bus_err_d    = 1'b0;
    case (state_q)
      MAU_IDLE: begin
        if (legal_op) begin
          state_d   = MAU_WAIT;
          cnt_d     = '0;
          req_d     = 1'b1;
          we_d      = mem_write_en;
          addr_d    = {mem_addr[ADDR_W-1:2], 2'b00};
          addr_lo_d = mem_addr[1:0];
          mode_d    = l_s_mode;
          be_d      = al_be;
          wdata_d   = al_wdata;
        end else if (op) begin
          addr_err_d = 1'b1;
        end
      end
      MAU_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (dbus_ack) begin
          state_d = MAU_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (!we_q) begin
            load_data_d  = al_load;
            load_valid_d = 1'b1;
          end
        end else if (TIMEOUT_CYCLES != 0 && cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d   = MAU_DONE;
          req_d     = 1'b0;
          we_d      = 1'b0;
          bus_err_d = 1'b1;
        end
      end
      default: state_d = MAU_IDLE;  // DONE: the op still presented is the one just served
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MAU_IDLE;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      addr_lo_q    <= '0;
      mode_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      addr_lo_q    <= addr_lo_d;
      mode_q       <= mode_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      addr_err_q   <= addr_err_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_be    = be_q;
  assign dbus_wdata = wdata_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign addr_err   = addr_err_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized ops against a per-transaction reference model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int T    = 4;
  localparam int MAXC = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_en, mem_write_en;
  logic [2:0]  l_s_mode;
  logic [31:0] mem_addr, store_data;
  logic        mem_stall, load_valid, addr_err, bus_err;
  logic [31:0] load_data;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;

  int n_checks = 0;
  int n_fail   = 0;

  int          obs_stall, obs_req, obs_lv, obs_ae, obs_berr;
  logic [31:0] obs_addr, obs_wdata, obs_ld;
  logic [3:0]  obs_be;
  logic        obs_we, obs_stable;
  logic [31:0] exp_ld_held;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .l_s_mode(l_s_mode),
    .mem_addr(mem_addr), .store_data(store_data),
    .mem_stall(mem_stall), .load_data(load_data), .load_valid(load_valid),
    .addr_err(addr_err), .bus_err(bus_err),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Presents one op at cycle 0 and holds it while the pipeline is stalled, as decode would;
  // ack is driven only in cycle ack_cyc (0 = never), plus an optional stray ack in cycle 0.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] mode,
                        input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                        input int ack_cyc, input logic stray);
    logic prev_stall, first;
    obs_stall = 0; obs_req = 0; obs_lv = 0; obs_ae = 0; obs_berr = 0;
    obs_addr = '0; obs_wdata = '0; obs_be = '0; obs_we = 1'b0; obs_stable = 1'b1;
    first = 1'b1;
    @(posedge clk); #1;
    mem_read_en = rd; mem_write_en = wr; l_s_mode = mode; mem_addr = addr;
    store_data = sd; dbus_rdata = rdata; dbus_ack = stray;
    prev_stall = 1'b0;
    for (int c = 0; c < MAXC; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (!prev_stall) begin mem_read_en = 1'b0; mem_write_en = 1'b0; end
        dbus_ack = (c == ack_cyc);
      end
      @(negedge clk);
      if (mem_stall)  obs_stall |= (1 << c);
      if (dbus_req)   obs_req   |= (1 << c);
      if (load_valid) obs_lv    |= (1 << c);
      if (addr_err)   obs_ae    |= (1 << c);
      if (bus_err)    obs_berr  |= (1 << c);
      if (dbus_req) begin
        if (first) begin
          obs_addr = dbus_addr; obs_be = dbus_be; obs_wdata = dbus_wdata; obs_we = dbus_we;
          first = 1'b0;
        end else if (dbus_addr !== obs_addr || dbus_be !== obs_be ||
                     dbus_wdata !== obs_wdata || dbus_we !== obs_we) begin
          obs_stable = 1'b0;
        end
      end
      prev_stall = mem_stall;
    end
    obs_ld = load_data;
    dbus_ack = 1'b0; mem_read_en = 1'b0; mem_write_en = 1'b0;
  endtask

  // Reference: what one op should produce, from access size, offset and wait count.
  function automatic void model(input logic rd, input logic wr, input logic [2:0] mode,
                                input logic [31:0] addr, input logic [31:0] sd,
                                input logic [31:0] rdata, input int ack_cyc,
                                output logic legal, output logic loads,
                                output int e_stall, output int e_req, output int e_lv,
                                output int e_ae, output int e_berr,
                                output logic [31:0] e_addr, output logic [3:0] e_be,
                                output logic [31:0] e_wdata, output logic [31:0] e_ld);
    int nbytes, off, bemask, last_wait;
    logic acked, sgn;
    logic [63:0] v;
    off    = int'(addr % 4);
    nbytes = (mode == L_S_WORD) ? 4 : (mode == L_S_HALF || mode == L_S_HALF_U) ? 2 :
             (mode == L_S_BYTE || mode == L_S_BYTE_U) ? 1 : 0;
    sgn    = (mode == L_S_BYTE || mode == L_S_HALF);
    if (nbytes == 0) legal = 1'b0;
    else legal = (rd || wr) && !(rd && wr) && ((off % nbytes) == 0);
    bemask  = ((1 << nbytes) - 1) << off;
    e_be    = bemask[3:0];
    e_addr  = addr - 32'(off);
    e_wdata = (nbytes == 1) ? (sd & 32'hFF) * 32'h0101_0101 :
              (nbytes == 2) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
    v = {32'b0, rdata} >> (8 * off);
    if (nbytes < 4) begin
      v = v & ((64'd1 << (8 * nbytes)) - 64'd1);
      if (sgn && v >= (64'd1 << (8 * nbytes - 1))) v = v - (64'd1 << (8 * nbytes));
    end
    e_ld  = v[31:0];
    acked = (ack_cyc >= 1) && (ack_cyc <= T);
    last_wait = acked ? ack_cyc : T;
    loads = legal && rd && acked;
    if (!legal) begin
      e_stall = 0; e_req = 0; e_lv = 0; e_berr = 0;
      e_ae = (rd || wr) ? 2 : 0;
    end else begin
      e_stall = (1 << (last_wait + 1)) - 1;
      e_req   = e_stall & ~1;
      e_lv    = loads ? (1 << (last_wait + 1)) : 0;
      e_berr  = acked ? 0 : (1 << (last_wait + 1));
      e_ae    = 0;
    end
  endfunction

  task automatic test_reset;
    rst = 1'b1; mem_read_en = 1'b0; mem_write_en = 1'b0; l_s_mode = L_S_WORD;
    mem_addr = '0; store_data = '0; dbus_ack = 1'b0; dbus_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, mem_stall, load_data,
         load_valid, addr_err, bus_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h be=%b wdata=%h stall=%b ld=%h lv=%b ae=%b be_err=%b, want all 0",
               dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, mem_stall, load_data,
               load_valid, addr_err, bus_err);
    end
    @(posedge clk); #1 rst = 1'b0;
    exp_ld_held = '0;
  endtask

  task automatic test_lb;
    run_op(1'b1, 1'b0, L_S_BYTE, 32'h1003, 32'h0, 32'h80FF_1234, 1, 1'b0);
    n_checks++; if (obs_stall !== 3) begin n_fail++; $display("FAIL lb_stall: got %b want %b", obs_stall, 3); end
    n_checks++; if (obs_req !== 2) begin n_fail++; $display("FAIL lb_req: got %b want %b", obs_req, 2); end
    n_checks++; if (obs_lv !== 4) begin n_fail++; $display("FAIL lb_valid: got %b want %b", obs_lv, 4); end
    n_checks++; if (obs_addr !== 32'h1000) begin n_fail++; $display("FAIL lb_addr: got %h want 00001000", obs_addr); end
    n_checks++; if (obs_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b want 1000", obs_be); end
    n_checks++; if (obs_ld !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %h want ffffff80", obs_ld); end
    exp_ld_held = 32'hFFFF_FF80;
  endtask

  task automatic test_lhu;
    run_op(1'b1, 1'b0, L_S_HALF_U, 32'h2002, 32'h0, 32'h9ABC_0000, 3, 1'b0);
    n_checks++; if (obs_stall !== 15) begin n_fail++; $display("FAIL lhu_stall: got %b want %b", obs_stall, 15); end
    n_checks++; if (obs_lv !== 16) begin n_fail++; $display("FAIL lhu_valid: got %b want %b", obs_lv, 16); end
    n_checks++; if (obs_be !== 4'b1100) begin n_fail++; $display("FAIL lhu_be: got %b want 1100", obs_be); end
    n_checks++; if (obs_ld !== 32'h0000_9ABC) begin n_fail++; $display("FAIL lhu_data: got %h want 00009abc", obs_ld); end
    exp_ld_held = 32'h0000_9ABC;
  endtask

  task automatic test_sb;
    run_op(1'b0, 1'b1, L_S_BYTE, 32'h3001, 32'h0000_00A5, 32'hDEAD_BEEF, 1, 1'b0);
    n_checks++; if (obs_req !== 2) begin n_fail++; $display("FAIL sb_req: got %b want %b", obs_req, 2); end
    n_checks++; if (obs_we !== 1'b1) begin n_fail++; $display("FAIL sb_we: got %b want 1", obs_we); end
    n_checks++; if (obs_be !== 4'b0010) begin n_fail++; $display("FAIL sb_be: got %b want 0010", obs_be); end
    n_checks++; if (obs_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h want a5a5a5a5", obs_wdata); end
    n_checks++; if (obs_lv !== 0) begin n_fail++; $display("FAIL sb_valid: got %b want 0", obs_lv); end
    n_checks++; if (obs_ld !== exp_ld_held) begin n_fail++; $display("FAIL sb_ld_hold: got %h want %h", obs_ld, exp_ld_held); end
  endtask

  task automatic test_addr_err;
    run_op(1'b1, 1'b0, L_S_WORD, 32'h4002, 32'h0, 32'h0, 1, 1'b0);
    n_checks++; if (obs_ae !== 2) begin n_fail++; $display("FAIL lw_mis_aerr: got %b want %b", obs_ae, 2); end
    n_checks++; if (obs_req !== 0) begin n_fail++; $display("FAIL lw_mis_req: got %b want 0", obs_req); end
    n_checks++; if (obs_stall !== 0) begin n_fail++; $display("FAIL lw_mis_stall: got %b want 0", obs_stall); end
    run_op(1'b1, 1'b1, L_S_WORD, 32'h4000, 32'h0, 32'h0, 1, 1'b0);
    n_checks++; if (obs_ae !== 2) begin n_fail++; $display("FAIL both_en_aerr: got %b want %b", obs_ae, 2); end
    n_checks++; if (obs_req !== 0) begin n_fail++; $display("FAIL both_en_req: got %b want 0", obs_req); end
  endtask

  task automatic test_timeout;
    run_op(1'b1, 1'b0, L_S_WORD, 32'h5000, 32'h0, 32'h1234_5678, 0, 1'b0);
    n_checks++; if (obs_req !== 30) begin n_fail++; $display("FAIL to_req: got %b want %b", obs_req, 30); end
    n_checks++; if (obs_berr !== 32) begin n_fail++; $display("FAIL to_bus_err: got %b want %b", obs_berr, 32); end
    n_checks++; if (obs_lv !== 0) begin n_fail++; $display("FAIL to_valid: got %b want 0", obs_lv); end
    n_checks++; if (obs_stall !== 31) begin n_fail++; $display("FAIL to_stall: got %b want %b", obs_stall, 31); end
  endtask

  task automatic test_reset_mid;
    int seen;
    @(posedge clk); #1;
    mem_read_en = 1'b1; l_s_mode = L_S_WORD; mem_addr = 32'h6000; dbus_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; mem_read_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, mem_stall, load_data,
         load_valid, addr_err, bus_err} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: req=%b addr=%h be=%b stall=%b ld=%h, want all 0",
               dbus_req, dbus_addr, dbus_be, mem_stall, load_data);
    end
    exp_ld_held = '0;
    seen = 0;
    @(posedge clk); #1 dbus_ack = 1'b1; dbus_rdata = $urandom;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (dbus_req || load_valid || mem_stall || bus_err) seen |= (1 << c);
      @(posedge clk); #1 dbus_ack = 1'b0;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_late_ack: activity %b want 0", seen); end
  endtask

  task automatic test_random;
    logic rd, wr, legal, loads, stray;
    logic [2:0] mode;
    logic [31:0] addr, sd, rdata, e_addr, e_wdata, e_ld;
    logic [3:0] e_be;
    int k, ack_cyc, e_stall, e_req, e_lv, e_ae, e_berr;
    for (int i = 0; i < 60; i++) begin
      k  = $urandom_range(0, 9);
      rd = (k == 0) || (k < 5);
      wr = (k == 0) || (k >= 5);
      mode    = 3'($urandom_range(0, 5));
      addr    = $urandom;
      sd      = $urandom;
      rdata   = $urandom;
      ack_cyc = $urandom_range(1, 7);
      stray   = 1'($urandom_range(0, 1));
      model(rd, wr, mode, addr, sd, rdata, ack_cyc, legal, loads,
            e_stall, e_req, e_lv, e_ae, e_berr, e_addr, e_be, e_wdata, e_ld);
      run_op(rd, wr, mode, addr, sd, rdata, ack_cyc, stray);
      if (loads) exp_ld_held = e_ld;
      n_checks++;
      if (obs_stall !== e_stall || obs_req !== e_req || obs_lv !== e_lv ||
          obs_ae !== e_ae || obs_berr !== e_berr) begin
        n_fail++;
        $display("FAIL rnd%0d_timing: stall/req/lv/ae/berr got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                 i, obs_stall, obs_req, obs_lv, obs_ae, obs_berr, e_stall, e_req, e_lv, e_ae, e_berr);
      end
      n_checks++;
      if (obs_ld !== exp_ld_held) begin
        n_fail++;
        $display("FAIL rnd%0d_load_data: got %h want %h (mode %0d addr %h rdata %h)",
                 i, obs_ld, exp_ld_held, mode, addr, rdata);
      end
      if (legal) begin
        n_checks++;
        if (obs_addr !== e_addr || obs_be !== e_be || obs_we !== wr ||
            (wr && obs_wdata !== e_wdata) || !obs_stable) begin
          n_fail++;
          $display("FAIL rnd%0d_bus: addr/be/we/wdata/stable got %h/%b/%b/%h/%b want %h/%b/%b/%h/1",
                   i, obs_addr, obs_be, obs_we, obs_wdata, obs_stable, e_addr, e_be, wr, e_wdata);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_lb;
    test_lhu;
    test_sb;
    test_addr_err;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Executes the memory side of the MIPS32 datapath.
- Consumes mem_read_en / mem_write_en / l_s_mode from the decode control and the ALU-computed address.
- Runs a request/acknowledge transaction on the data bus and returns an aligned, sign- or zero-extended load result to writeback.
- Stalls the pipeline while a transaction is outstanding.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, bus/register width; fixed at 32, byte lanes = 4
- TIMEOUT_CYCLES, 256, WAIT cycles without ack before bus_err; 0 disables the timeout

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- mem_read_en  in  1  load requested this cycle
- mem_write_en  in  1  store requested this cycle
- l_s_mode  in  L_S_MODE_W  L_S_BYTE / BYTE_U / HALF / HALF_U / WORD
- mem_addr  in  ADDR_W  effective address (ALU result)
- store_data  in  DATA_W  rt value for stores
- mem_stall  out  1  freeze upstream stages
- load_data  out  DATA_W  extended load result
- load_valid  out  1  load_data valid; one-cycle pulse
- addr_err  out  1  misaligned or illegal access; one-cycle pulse
- bus_err  out  1  timeout pulse
- dbus_req  out  1  bus request
- dbus_we  out  1  1 = write
- dbus_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0
- dbus_be  out  4  byte enables, bit i = bits [8i+7:8i]
- dbus_wdata  out  DATA_W  lane-replicated store data
- dbus_ack  in  1  transaction complete; rdata valid for reads
- dbus_rdata  in  DATA_W  read word

Behaviour:
- Reset:
  - Sync, active-high; state IDLE.
  - All outputs 0: dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, mem_stall, load_data, load_valid, addr_err, bus_err. Timeout counter 0.
- States: IDLE, WAIT, DONE.
- IDLE, acceptance:
  - op = mem_read_en | mem_write_en.
  - mem_stall is combinationally 1 whenever a legal op is present.
  - A legal op latches addr, mode, we and lane data, then goes to WAIT.
- IDLE, illegal op:
  - Illegal means both enables high, HALF* with addr[0]=1, or WORD with addr[1:0]≠0.
  - Response: addr_err=1 next cycle for one cycle, no bus activity, mem_stall=0, stay IDLE.
- WAIT:
  - dbus_req=1; all dbus_* outputs held stable until ack.
  - mem_stall=1; the counter increments each cycle.
  - On dbus_ack: capture the formatted rdata, go to DONE. The counter is not checked in that cycle.
  - Counter reaching TIMEOUT_CYCLES (nonzero) without ack: drop req, bus_err=1 next cycle, go to DONE with load_valid=0.
- DONE (one cycle):
  - dbus_req=0, mem_stall=0.
  - load_valid=1 only for a completed read; load_data holds until the next load completes.
  - Always returns to IDLE. An op present in the DONE cycle is the already-served instruction and is ignored.
- Latency:
  - Op presented at cycle 0; req high from cycle 1.
  - Ack sampled at cycle k gives DONE at k+1.
  - Zero-wait memory (ack at cycle 1): stall is high for cycles 0–1, result at cycle 2.
- dbus_ack outside WAIT is ignored.
- Store formatting (little-endian):
  - BYTE: wdata = {4{sd[7:0]}}, be = 1<<addr[1:0].
  - HALF: wdata = {2{sd[15:0]}}, be = addr[1] ? 1100 : 0011.
  - WORD: wdata = sd, be = 1111.
- Load formatting:
  - Select the lane by addr[1:0].
  - BYTE / HALF sign-extend; BYTE_U / HALF_U zero-extend.
  - WORD is passed through.
  - Reads drive be per mode as for stores.
- Reset mid-transaction: req drops on the next edge and the transaction is abandoned; the bus must tolerate this.

Decomposition:
- defines.v, existing: L_S_MODE_W and L_S_* encodings.
- defines.v, added:
  - state encodings MAU_IDLE / MAU_WAIT / MAU_DONE
  - DBUS_BE_W=4
  - default TIMEOUT_CYCLES
- Sub-module mem_lane_align: purely combinational; (mode, addr[1:0], store_data, rdata) → (be, wdata, load_data, misaligned). Shared with a future instruction-side cache fill.

Test Plan:
- LB, addr 0x1003, rdata 0x80FF_1234, ack on first WAIT cycle → dbus_addr 0x1000, be 1000, load_data 0xFFFF_FF80, load_valid at cycle 2, mem_stall high cycles 0–1.
- LHU, addr 0x2002, rdata 0x9ABC_0000, ack after 3 WAIT cycles → load_data 0x0000_9ABC, stall 4 cycles.
- SB, addr 0x3001, store_data 0x0000_00A5 → req, we=1, be 0010, wdata 0xA5A5_A5A5; no load_valid.
- LW, addr 0x4002 → addr_err pulse at cycle 1, dbus_req never high, mem_stall 0. Repeat with read_en=write_en=1 → addr_err.
- TIMEOUT_CYCLES=4, LW with ack never asserted → req high 4 cycles, bus_err pulse, load_valid 0, back to IDLE.
- rst asserted in the 2nd WAIT cycle → next edge all outputs 0, state IDLE; a later ack is ignored.
